// File: rtl/bks_sub32_pipe.sv
// Three-stage pipelined 32-bit Brent-Kung subtractor: Diff = A - B - Bin, computed as A + ~B + ~Bin.
// Valid/ready handshake on both sides; only the output registers and valid bits carry reset.
module bks_sub32_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Ovf
);

    logic             adv1, adv2, adv3;
    logic             vld_p1_q, vld_p2_q, vld_p3_q;
    logic             vld_p1_d, vld_p2_d, vld_p3_d;

    logic [WIDTH-1:0] g_p1_q, p_p1_q;
    logic             c0_p1_q;

    logic [WIDTH-1:0] ug, up;
    logic [6:0]       pg2_d;
    logic [2:0]       pg4_d;
    logic             pg8_d;

    logic [WIDTH-1:0] gu_p2_q, p_p2_q;
    logic [6:0]       pg2_p2_q;
    logic [2:0]       pg4_p2_q;
    logic             pg8_p2_q;
    logic             c0_p2_q;

    logic [WIDTH-1:0] cg, carry, diff_d;
    logic             bout_d, ovf_d;

    logic [WIDTH-1:0] diff_p3_q;
    logic             bout_p3_q, ovf_p3_q;

    // A stage may take new contents when it is empty or its successor is moving on.
    assign adv3     = ~vld_p3_q | out_ready;
    assign adv2     = ~vld_p2_q | adv3;
    assign adv1     = ~vld_p1_q | adv2;
    assign in_ready = adv1;

    always_comb begin
        vld_p1_d = vld_p1_q;
        vld_p2_d = vld_p2_q;
        vld_p3_d = vld_p3_q;
        if (adv1) vld_p1_d = in_valid;
        if (adv2) vld_p2_d = vld_p1_q;
        if (adv3) vld_p3_d = vld_p2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            vld_p3_q <= vld_p3_d;
        end
    end

    // ---- S1: bitwise generate/propagate of A + ~B, carry-in ~Bin ----
    always_ff @(posedge clk) begin
        if (adv1 && in_valid) begin
            g_p1_q  <= A & ~B;
            p_p1_q  <= ~(A ^ B);
            c0_p1_q <= ~Bin;
        end
    end

    // In-place up-sweep: afterwards position i holds the group ending at i whose span is 2^tz(i+1).
    always_comb begin
        ug    = g_p1_q;
        up    = p_p1_q;
        ug[0] = g_p1_q[0] | (p_p1_q[0] & c0_p1_q);
        for (int l = 1; l <= 5; l++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if ((i & ((1 << l) - 1)) == ((1 << l) - 1)) begin
                    ug[i] = ug[i] | (up[i] & ug[i - (1 << (l - 1))]);
                    up[i] = up[i] & up[i - (1 << (l - 1))];
                end
            end
        end
        for (int k = 0; k < 7; k++) pg2_d[k] = up[4*k + 5];
        for (int k = 0; k < 3; k++) pg4_d[k] = up[8*k + 11];
        pg8_d = up[23];
    end

    // ---- S2: up-sweep tree nodes plus the raw propagate vector ----
    always_ff @(posedge clk) begin
        if (adv2 && vld_p1_q) begin
            gu_p2_q  <= ug;
            p_p2_q   <= p_p1_q;
            pg2_p2_q <= pg2_d;
            pg4_p2_q <= pg4_d;
            pg8_p2_q <= pg8_d;
            c0_p2_q  <= c0_p1_q;
        end
    end

    // Down-sweep at half-spans 8, 4, 2, 1; the only group-P nodes still needed are the ones kept in S2.
    always_comb begin
        cg     = gu_p2_q;
        cg[23] = cg[23] | (pg8_p2_q & cg[15]);
        for (int k = 0; k < 3; k++)
            cg[8*k + 11] = cg[8*k + 11] | (pg4_p2_q[k] & cg[8*k + 7]);
        for (int k = 0; k < 7; k++)
            cg[4*k + 5] = cg[4*k + 5] | (pg2_p2_q[k] & cg[4*k + 3]);
        for (int k = 0; k < 15; k++)
            cg[2*k + 2] = cg[2*k + 2] | (p_p2_q[2*k + 2] & cg[2*k + 1]);
        carry  = {cg[WIDTH-2:0], c0_p2_q};
        diff_d = p_p2_q ^ carry;
        bout_d = ~cg[WIDTH-1];
        ovf_d  = cg[WIDTH-1] ^ cg[WIDTH-2];
    end

    // ---- S3: output register, cleared by reset so outputs read zero while rst_n is low ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_p3_q <= '0;
            bout_p3_q <= 1'b0;
            ovf_p3_q  <= 1'b0;
        end else if (adv3 && vld_p2_q) begin
            diff_p3_q <= diff_d;
            bout_p3_q <= bout_d;
            ovf_p3_q  <= ovf_d;
        end
    end

    assign out_valid = vld_p3_q;
    assign Diff      = diff_p3_q;
    assign Bout      = bout_p3_q;
    assign Ovf       = ovf_p3_q;

endmodule

// File: tb/tb_bks_sub32_pipe.sv
// Self-checking bench for bks_sub32_pipe: directed vectors plus randomized traffic with
// random backpressure, scored in order against a 33-bit arithmetic reference model.
module tb_bks_sub32_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] A, B, Diff;
    logic        Bin, out_valid, out_ready, Bout, Ovf;

    typedef struct packed {
        logic [31:0] diff;
        logic        bout;
        logic        ovf;
    } exp_t;

    exp_t q[$];
    exp_t cur_exp;
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_acc    = 0;

    always #5 clk = ~clk;

    bks_sub32_pipe #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff      (Diff),
        .Bout      (Bout),
        .Ovf       (Ovf)
    );

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic bin);
        logic [32:0] full;
        exp_t        e;
        full   = {1'b0, a} - {1'b0, b} - {32'd0, bin};
        e.diff = full[31:0];
        e.bout = full[32];
        e.ovf  = (a[31] != b[31]) && (e.diff[31] != a[31]);
        return e;
    endfunction

    function automatic exp_t mk(input logic [31:0] d, input logic bo, input logic ov);
        exp_t e;
        e.diff = d;
        e.bout = bo;
        e.ovf  = ov;
        return e;
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: expected results queued on input transfer, compared in order on output transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                check("out_has_expected", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    mon_e = q.pop_front();
                    check("diff", Diff, mon_e.diff);
                    check("bout", 32'(Bout), 32'(mon_e.bout));
                    check("ovf", 32'(Ovf), 32'(mon_e.ovf));
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(cur_exp);
                n_acc++;
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic bin,
                        input exp_t e, output int waits);
        bit got;
        got      = 1'b0;
        waits    = 0;
        A        = a;
        B        = b;
        Bin      = bin;
        cur_exp  = e;
        in_valid = 1'b1;
        while (!got && waits < 200) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
            else waits++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("send_accept", 32'(got), 32'd1);
    endtask

    task automatic drain();
        int k;
        k         = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while (q.size() != 0 && k < 100) begin
            @(negedge clk);
            @(posedge clk);
            #1;
            k++;
        end
        check("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        int          idx;
        int          sent;
        int          budget;
        bit          pending;
        bit          fire;
        bit          have_hold;
        logic [31:0] hold_d;
        logic [31:0] oh;
        logic [31:0] a_bp[5];
        logic [31:0] b_bp[5];
        logic        c_bp[5];
        logic [31:0] ra, rb;
        logic        rc;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        A         = '0;
        B         = '0;
        Bin       = 1'b0;
        out_ready = 1'b0;
        cur_exp   = '0;

        // Reset state
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_diff", Diff, 32'd0);
        check("rst_bout", 32'(Bout), 32'd0);
        check("rst_ovf", 32'(Ovf), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Latency: handshake cycle, then result visible in the third following cycle
        out_ready = 1'b1;
        A         = 32'd5;
        B         = 32'd3;
        Bin       = 1'b0;
        cur_exp   = mk(32'h0000_0002, 1'b0, 1'b0);
        in_valid  = 1'b1;
        @(negedge clk);
        check("lat_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("lat_out_valid", 32'(out_valid), 32'(k == 3));
        end
        @(posedge clk);
        #1;

        // Back-to-back directed vectors, including full borrow ripple
        send(32'h0000_0005, 32'h0000_0003, 1'b0, mk(32'h0000_0002, 1'b0, 1'b0), w);
        send(32'h0000_0000, 32'h0000_0000, 1'b1, mk(32'hFFFF_FFFF, 1'b1, 1'b0), w);
        check("b2b_tput", 32'(w), 32'd0);
        send(32'h8000_0000, 32'h0000_0001, 1'b0, mk(32'h7FFF_FFFF, 1'b0, 1'b1), w);
        check("b2b_tput", 32'(w), 32'd0);
        send(32'h0000_0000, 32'hFFFF_FFFF, 1'b1, mk(32'h0000_0000, 1'b1, 1'b0), w);
        check("b2b_tput", 32'(w), 32'd0);
        drain();

        // Single-bit walk
        for (int i = 0; i < 32; i++) begin
            oh = 32'h1 << i;
            send(oh, oh, 1'b0, mk(32'h0, 1'b0, 1'b0), w);
            check("walk_tput", 32'(w), 32'd0);
            send(32'h0, oh, 1'b0, mk(32'h0 - oh, 1'b1, 1'(i == 31)), w);
            check("walk_tput", 32'(w), 32'd0);
        end
        drain();

        // Backpressure: five offered with out_ready low, exactly three taken, outputs frozen
        for (int k = 0; k < 5; k++) begin
            a_bp[k] = rnd_op();
            b_bp[k] = rnd_op();
            c_bp[k] = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b0;
        idx       = 0;
        have_hold = 1'b0;
        hold_d    = '0;
        for (int c = 0; c < 8; c++) begin
            if (idx < 5) begin
                A        = a_bp[idx];
                B        = b_bp[idx];
                Bin      = c_bp[idx];
                cur_exp  = model(a_bp[idx], b_bp[idx], c_bp[idx]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            fire = in_valid && in_ready;
            if (out_valid) begin
                if (!have_hold) begin
                    hold_d    = Diff;
                    have_hold = 1'b1;
                end else begin
                    check("bp_diff_hold", Diff, hold_d);
                end
            end
            @(posedge clk);
            #1;
            if (fire) idx++;
        end
        check("bp_accepted", 32'(idx), 32'd3);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        while (idx < 5) begin
            send(a_bp[idx], b_bp[idx], c_bp[idx], model(a_bp[idx], b_bp[idx], c_bp[idx]), w);
            idx++;
        end
        drain();

        // Randomized traffic with random backpressure
        sent    = 0;
        budget  = 0;
        pending = 1'b0;
        while (sent < 1000 && budget < 20000) begin
            if (!pending && $urandom_range(0, 9) < 7) begin
                ra       = rnd_op();
                rb       = rnd_op();
                rc       = 1'($urandom_range(0, 1));
                A        = ra;
                B        = rb;
                Bin      = rc;
                cur_exp  = model(ra, rb, rc);
                in_valid = 1'b1;
                pending  = 1'b1;
            end
            out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            if (in_valid && in_ready) begin
                pending = 1'b0;
                sent++;
            end
            @(posedge clk);
            #1;
            if (!pending) in_valid = 1'b0;
            budget++;
        end
        check("rnd_sent", 32'(sent), 32'd1000);
        drain();

        // Reset with three results in flight
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ra = rnd_op();
            rb = rnd_op();
            send(ra, rb, 1'b0, model(ra, rb, 1'b0), w);
        end
        check("rst_mid_full", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_diff", Diff, 32'd0);
        check("rst_mid_bout", 32'(Bout), 32'd0);
        check("rst_mid_ovf", 32'(Ovf), 32'd0);
        q.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rst_post_out_valid", 32'(out_valid), 32'd0);
        end
        check("rst_post_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
